// File: rtl/id_defs.sv
// Shared encodings and payload types for the instruction-decode stage.
package id_defs;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned REG_NUM = 32;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned ALU_W   = 3;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned IMM_W   = 16;

   localparam logic [DATA_W-1:0] NOP_INST_DEF = 32'h0000_0000;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;

   localparam logic [OP_W-1:0] FN_ADD = 6'h20;
   localparam logic [OP_W-1:0] FN_SUB = 6'h22;
   localparam logic [OP_W-1:0] FN_AND = 6'h24;
   localparam logic [OP_W-1:0] FN_OR  = 6'h25;
   localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

   localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic             jump;
      logic             branch;
      logic             reg_dst;
      logic             alu_src;
      logic             mem_read;
      logic             mem_write;
      logic             mem_to_reg;
      logic             reg_write;
      logic [ALU_W-1:0] alu_ctr;
   } ctrl_t;

   typedef struct packed {
      ctrl_t              ctrl;
      logic [DATA_W-1:0]  branch_target;
      logic [DATA_W-1:0]  jump_target;
      logic [DATA_W-1:0]  rs_data;
      logic [DATA_W-1:0]  rt_data;
      logic [DATA_W-1:0]  imm;
      logic [REG_AW-1:0]  rt;
      logic [REG_AW-1:0]  rd;
   } idex_t;

   function automatic logic [DATA_W-1:0] sext16(input logic [IMM_W-1:0] v);
      return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
   endfunction

endpackage

// File: rtl/regfile_32x32.sv
// 32x32 register file: two combinational read ports with write-first bypass,
// one synchronous write port, synchronous active-low clear; $0 reads as zero.
module regfile_32x32
   import id_defs::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] ra1,
   input  logic [REG_AW-1:0] ra2,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rdata1_c,
   output logic [DATA_W-1:0] rdata2_c
);

   logic [DATA_W-1:0] regs [REG_NUM];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < REG_NUM; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   // Same-cycle write-back is forwarded so decode never sees a stale value.
   always_comb begin
      rdata1_c = regs[ra1];
      if (ra1 == '0) begin
         rdata1_c = '0;
      end else if (we && (wa == ra1)) begin
         rdata1_c = wd;
      end
   end

   always_comb begin
      rdata2_c = regs[ra2];
      if (ra2 == '0) begin
         rdata2_c = '0;
      end else if (we && (wa == ra2)) begin
         rdata2_c = wd;
      end
   end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, control decode, register file,
// load-use hazard detection and registered ID/EX outputs.
module id_stage
   import id_defs::*;
#(
   parameter logic [DATA_W-1:0] NOP_INST = NOP_INST_DEF
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [DATA_W-1:0] Inst,
   input  logic [DATA_W-1:0] PC,
   input  logic              Flush,
   output logic              Stall_out,
   input  logic              WB_RegWrite,
   input  logic [REG_AW-1:0] WB_WriteReg,
   input  logic [DATA_W-1:0] WB_WriteData,
   output logic              Jump,
   output logic              Branch,
   output logic [DATA_W-1:0] BranchTarget,
   output logic [DATA_W-1:0] JumpTarget,
   output logic [DATA_W-1:0] RsData,
   output logic [DATA_W-1:0] RtData,
   output logic [DATA_W-1:0] Imm,
   output logic [REG_AW-1:0] Rt,
   output logic [REG_AW-1:0] Rd,
   output logic              RegDst,
   output logic              ALUSrc,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              MemtoReg,
   output logic              RegWrite,
   output logic [ALU_W-1:0]  ALUCtr
);

   logic [DATA_W-1:0] ifid_instr;
   logic [DATA_W-1:0] ifid_pc;
   idex_t             idex_q;
   idex_t             idex_d;
   ctrl_t             ctrl;

   logic [OP_W-1:0]   op;
   logic [OP_W-1:0]   funct;
   logic [REG_AW-1:0] rs;
   logic [REG_AW-1:0] rt;
   logic [REG_AW-1:0] rd;
   logic [DATA_W-1:0] pc4;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;

   assign op      = ifid_instr[31:26];
   assign rs      = ifid_instr[25:21];
   assign rt      = ifid_instr[20:16];
   assign rd      = ifid_instr[15:11];
   assign funct   = ifid_instr[5:0];
   assign pc4     = ifid_pc + DATA_W'(4);
   assign imm_ext = sext16(ifid_instr[15:0]);

   regfile_32x32 u_regfile (
      .clk      (Clk),
      .rst_n    (Rst_n),
      .ra1      (rs),
      .ra2      (rt),
      .we       (WB_RegWrite),
      .wa       (WB_WriteReg),
      .wd       (WB_WriteData),
      .rdata1_c (rs_data),
      .rdata2_c (rt_data)
   );

   // Control decode; unknown opcodes fall through as a bubble.
   always_comb begin
      ctrl = '0;
      case (op)
         OP_RTYPE: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            case (funct)
               FN_ADD:  ctrl.alu_ctr = ALU_ADD;
               FN_SUB:  ctrl.alu_ctr = ALU_SUB;
               FN_AND:  ctrl.alu_ctr = ALU_AND;
               FN_OR:   ctrl.alu_ctr = ALU_OR;
               FN_SLT:  ctrl.alu_ctr = ALU_SLT;
               default: begin
                  ctrl.reg_write = 1'b0;
                  ctrl.alu_ctr   = '0;
               end
            endcase
         end
         OP_LW: begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.alu_ctr    = ALU_ADD;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.alu_ctr   = ALU_ADD;
         end
         OP_BEQ: begin
            ctrl.branch  = 1'b1;
            ctrl.alu_ctr = ALU_SUB;
         end
         OP_ADDI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.alu_ctr   = ALU_ADD;
         end
         OP_J: begin
            ctrl.jump = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      idex_d               = '0;
      idex_d.ctrl          = ctrl;
      idex_d.branch_target = pc4 + {imm_ext[DATA_W-3:0], 2'b00};
      idex_d.jump_target   = {pc4[31:28], ifid_instr[25:0], 2'b00};
      idex_d.rs_data       = rs_data;
      idex_d.rt_data       = rt_data;
      idex_d.imm           = imm_ext;
      idex_d.rt            = rt;
      idex_d.rd            = rd;
   end

   // Load-use: the load in ID/EX targets a register the IF/ID instruction reads.
   assign Stall_out = idex_q.ctrl.mem_read && (idex_q.rt != '0) &&
                      ((idex_q.rt == rs) || (idex_q.rt == rt));

   always_ff @(posedge Clk) begin
      if (!Rst_n || Flush) begin
         ifid_instr <= NOP_INST;
         ifid_pc    <= '0;
         idex_q     <= '0;
      end else if (Stall_out) begin
         idex_q <= '0;
      end else begin
         ifid_instr <= Inst;
         ifid_pc    <= PC;
         idex_q     <= idex_d;
      end
   end

   assign Jump         = idex_q.ctrl.jump;
   assign Branch       = idex_q.ctrl.branch;
   assign RegDst       = idex_q.ctrl.reg_dst;
   assign ALUSrc       = idex_q.ctrl.alu_src;
   assign MemRead      = idex_q.ctrl.mem_read;
   assign MemWrite     = idex_q.ctrl.mem_write;
   assign MemtoReg     = idex_q.ctrl.mem_to_reg;
   assign RegWrite     = idex_q.ctrl.reg_write;
   assign ALUCtr       = idex_q.ctrl.alu_ctr;
   assign BranchTarget = idex_q.branch_target;
   assign JumpTarget   = idex_q.jump_target;
   assign RsData       = idex_q.rs_data;
   assign RtData       = idex_q.rt_data;
   assign Imm          = idex_q.imm;
   assign Rt           = idex_q.rt;
   assign Rd           = idex_q.rd;

endmodule
